uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the command parser. It accepts one byte per `tx_start_i`/`tx_ready_o` handshake and shifts it out LSB-first on a single serial line: start bit, 8 data bits, optional parity, then 1 or 2 stop bits. Bit timing comes from an internal divider on the system clock. The parser holds no byte-level state for the link, so this block owns framing, pacing and the ready indication.

## Interface
- `CLKS_PER_BIT`, 868, system clocks per serial bit (100 MHz / 115200); legal range ≥ 2.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; the only clock; all logic on rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `tx_start_i`  in  1  request to send `tx_data_i`; sampled only while `tx_ready_o` = 1.
- `tx_data_i`  in  8  byte to send; captured on the accepting edge.
- `tx_ready_o`  out  1  1 = idle and able to accept a byte.
- `tx_o`  out  1  serial line; idle level 1.
- `tx_done_o`  out  1  one-cycle pulse when the last stop bit has completed.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Registers:**
  - Bit-period counter `bcnt`, width `$clog2(CLKS_PER_BIT)`.
  - Bit index `bidx`, 3 bits.
  - Shift register `sh`, 8 bits.
  - Parity accumulator `par`.
  - Stop counter `scnt`, 1 bit.
- **IDLE:**
  - `tx_o` = 1 and `tx_ready_o` = 1.
  - If `tx_start_i` = 1: `sh` ← `tx_data_i`, `par` ← (`PARITY` = 1 ? 1 : 0), `bcnt` ← 0, go to START.
- **START:** `tx_o` = 0 for `CLKS_PER_BIT` cycles, then `bidx` ← 0 and go to DATA.
- **DATA:**
  - `tx_o` = `sh[0]`.
  - When `bcnt` = `CLKS_PER_BIT`−1: `par` ^= `sh[0]`, `sh` ← `sh >> 1`, `bcnt` ← 0.
  - On `bidx` = 7 go to PARITY if `PARITY` ≠ 0, else to STOP; otherwise `bidx`++.
- **PARITY:** `tx_o` = `par` for one bit period, then go to STOP.
  - Odd mode: the line carries XOR(data) ^ 1.
  - Even mode: the line carries XOR(data).
- **STOP:**
  - `tx_o` = 1 for `STOP_BITS` bit periods, counted by `scnt`.
  - On the final stop-bit cycle: pulse `tx_done_o` and go to IDLE.
- **Bit counter:** `bcnt` counts 0..`CLKS_PER_BIT`−1 and wraps to 0 at each bit boundary. It never exceeds `CLKS_PER_BIT`−1.
- **`tx_ready_o` decode:** decoded from the state register as (state = IDLE); no extra register.
- **`tx_o` source:** driven from a register so the line is glitch-free.
- **Ignored inputs:**
  - `tx_start_i` outside IDLE is ignored and not queued.
  - `tx_data_i` changes after acceptance have no effect on the frame in flight.
- **Reset mid-frame:** on the next edge the frame is abandoned with no `tx_done_o` pulse. All registers return to reset values.
- **Reset values:**
  - State = IDLE, `tx_o` = 1, `tx_ready_o` = 1, `tx_done_o` = 0.
  - `bcnt` = 0, `bidx` = 0, `sh` = 0, `par` = 0, `scnt` = 0.

## Timing
- **Accept edge E:** the rising edge where IDLE and `tx_start_i` = 1.
  - `tx_ready_o` = 0 from E+1; the parser's wait-for-ready check one cycle later sees it low.
  - `tx_o` falls in the cycle following E. The start bit occupies cycles E+1 .. E+`CLKS_PER_BIT`.
- **Bit placement:** data bit k occupies cycles E+1+(1+k)·`CLKS_PER_BIT` .. +`CLKS_PER_BIT`−1.
- **Frame length:** F = (1 + 8 + (`PARITY`≠0) + `STOP_BITS`) · `CLKS_PER_BIT` cycles.
- **End of frame:**
  - `tx_done_o` is high in cycle E+F, the last stop-bit cycle.
  - `tx_ready_o` returns to 1 in cycle E+F+1.
- **Back-to-back:** a start held or re-asserted in cycle E+F+1 is accepted at that edge. The next start bit begins at E+F+2, giving exactly one extra idle cycle between frames.
- **Throughput:** one byte per F+1 cycles maximum.

## Test plan
Unless stated, benches run with `CLKS_PER_BIT`=4, `PARITY`=0, `STOP_BITS`=1.

- **Reset:** hold `rstn`=0 for 3 cycles, then release → `tx_o`=1, `tx_ready_o`=1, `tx_done_o`=0 throughout; no line activity.
- **Single byte:** one-cycle `tx_start_i` with 8'hA5 → `tx_ready_o`=0 next cycle.
  - Line samples at bit centres: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done_o` pulses once at cycle E+40; `tx_ready_o`=1 at E+41.
- **Parity and stop bits:** `PARITY`=2, `STOP_BITS`=2, byte 8'h07 → parity bit 1, then two stop bits of 4 cycles each; F=48.
  - Repeat with `PARITY`=1 → parity bit 0.
- **Busy-time inputs:** pulse `tx_start_i` with 8'hFF mid-frame of 8'h00 → ignored; only the 8'h00 frame appears.
  - Changing `tx_data_i` mid-frame does not alter the bits sent.
- **Back-to-back:** hold `tx_start_i`=1 with the data sequence 8'h55, then 8'h0F → second start bit at E+42.
  - Exactly one idle-high cycle between frames; two `tx_done_o` pulses.
- **Reset mid-frame:** assert `rstn`=0 during data bit 3 → `tx_o`=1 and `tx_ready_o`=1 on the next edge, no `tx_done_o`.
  - A subsequent byte 8'h3C transmits correctly.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Byte-to-serial link between the command parser (master) and the UART
// transmit serializer (slave).
//
// Handshake: the master raises tx_start_i with tx_data_i valid; a byte is
// accepted on any rising edge where tx_start_i = 1 and tx_ready_o = 1.
// tx_start_i while tx_ready_o = 0 is ignored (not queued), and tx_data_i
// only matters on the accepting edge. tx_done_o pulses for one cycle in
// the last stop-bit cycle of each frame that completes.
interface uart_tx_serializer_if;
   logic       tx_start_i;
   logic [7:0] tx_data_i;
   logic       tx_ready_o;
   logic       tx_o;
   logic       tx_done_o;

   // Parser side: drives the request, observes ready / line / done.
   modport master (
      output tx_start_i,
      output tx_data_i,
      input  tx_ready_o,
      input  tx_o,
      input  tx_done_o
   );

   // Serializer side: samples the request, drives ready / line / done.
   modport slave (
      input  tx_start_i,
      input  tx_data_i,
      output tx_ready_o,
      output tx_o,
      output tx_done_o
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte per start/ready handshake and
// sends start bit, 8 data bits LSB-first, optional parity and 1 or 2 stop
// bits. Bit pacing comes from a divider on the system clock. The line and
// the done pulse are registered; ready is decoded from the state register.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,  // system clocks per serial bit, >= 2
   parameter int PARITY       = 0,    // 0 = none, 1 = odd, 2 = even
   parameter int STOP_BITS    = 1     // 1 or 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   uart_tx_serializer_if.slave   bus,
   output logic [2:0]            dbg_state
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BPRE = BW'(CLKS_PER_BIT - 2);
   localparam logic          SLAST = 1'(STOP_BITS - 1);
   localparam logic          PAR_INIT = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t        state;
   logic [BW-1:0] bcnt;    // clocks elapsed in the current bit period
   logic [2:0]    bidx;    // data bit being sent
   logic [7:0]    sh;      // remaining data bits, current bit in sh[0]
   logic          par;     // running parity, seeded with 1 for odd mode
   logic          scnt;    // stop bit being sent
   logic          tx_q;    // registered serial line
   logic          done_q;  // registered end-of-frame pulse

   logic bit_end;
   logic last_stop;

   assign bit_end   = (bcnt == BMAX);
   assign last_stop = (scnt == SLAST);

   // Framing FSM. tx_q is always loaded with the level of the coming
   // cycle, so each transition also selects the next line value.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= S_IDLE;
         bcnt   <= '0;
         bidx   <= '0;
         sh     <= '0;
         par    <= 1'b0;
         scnt   <= 1'b0;
         tx_q   <= 1'b1;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               tx_q <= 1'b1;
               bcnt <= '0;
               if (bus.tx_start_i) begin
                  sh    <= bus.tx_data_i;
                  par   <= PAR_INIT;
                  state <= S_START;
                  tx_q  <= 1'b0;
               end
            end

            S_START: begin
               if (bit_end) begin
                  bcnt  <= '0;
                  bidx  <= '0;
                  state <= S_DATA;
                  tx_q  <= sh[0];
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  bcnt <= '0;
                  par  <= par ^ sh[0];
                  sh   <= sh >> 1;
                  if (bidx == 3'd7) begin
                     if (PARITY != 0) begin
                        state <= S_PARITY;
                        tx_q  <= par ^ sh[0];
                     end else begin
                        state <= S_STOP;
                        scnt  <= 1'b0;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     bidx <= bidx + 1'b1;
                     // next data bit is the one about to shift into sh[0]
                     tx_q <= sh[1];
                  end
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (bit_end) begin
                  bcnt  <= '0;
                  state <= S_STOP;
                  scnt  <= 1'b0;
                  tx_q  <= 1'b1;
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end

            S_STOP: begin
               tx_q <= 1'b1;
               // raise done one edge early so it is high in the final cycle
               if (last_stop && (bcnt == BPRE)) begin
                  done_q <= 1'b1;
               end
               if (bit_end) begin
                  bcnt <= '0;
                  if (last_stop) begin
                     state <= S_IDLE;
                     scnt  <= 1'b0;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               tx_q  <= 1'b1;
               bcnt  <= '0;
            end
         endcase
      end
   end

   assign bus.tx_ready_o = (state == S_IDLE);
   assign bus.tx_o       = tx_q;
   assign bus.tx_done_o  = done_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no parity / 1 stop,
// even parity / 2 stop, odd parity / 2 stop) at 4 clocks per bit. Frames
// are pushed to per-instance expected queues when driven and compared by
// line monitors that sample bit centres and frame timing.
module tb_uart_tx_serializer;

   localparam int C = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;

   // ---------------- DUTs ----------------
   logic       start_d [3];
   logic [7:0] data_d  [3];
   logic       rdy [3];
   logic       txl [3];
   logic       dn  [3];
   logic [2:0] dbg0, dbg1, dbg2;

   uart_tx_serializer_if bus0 ();
   uart_tx_serializer_if bus1 ();
   uart_tx_serializer_if bus2 ();

   assign bus0.tx_start_i = start_d[0];
   assign bus0.tx_data_i  = data_d[0];
   assign bus1.tx_start_i = start_d[1];
   assign bus1.tx_data_i  = data_d[1];
   assign bus2.tx_start_i = start_d[2];
   assign bus2.tx_data_i  = data_d[2];

   assign rdy[0] = bus0.tx_ready_o;
   assign txl[0] = bus0.tx_o;
   assign dn[0]  = bus0.tx_done_o;
   assign rdy[1] = bus1.tx_ready_o;
   assign txl[1] = bus1.tx_o;
   assign dn[1]  = bus1.tx_done_o;
   assign rdy[2] = bus2.tx_ready_o;
   assign txl[2] = bus2.tx_o;
   assign dn[2]  = bus2.tx_done_o;

   uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rstn(rstn), .bus(bus0), .dbg_state(dbg0));
   uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rstn(rstn), .bus(bus1), .dbg_state(dbg1));
   uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rstn(rstn), .bus(bus2), .dbg_state(dbg2));

   // ---------------- scoreboard ----------------
   logic [11:0] exp_q0[$];
   logic [11:0] exp_q1[$];
   logic [11:0] exp_q2[$];
   int frames_exp [3] = '{0, 0, 0};
   int done_cnt   [3] = '{0, 0, 0};
   int acc_cyc    [3] = '{0, 0, 0};
   int acc_prev   [3] = '{0, 0, 0};

   always @(negedge clk) begin
      done_cnt[0] <= done_cnt[0] + ((dn[0] === 1'b1) ? 1 : 0);
      done_cnt[1] <= done_cnt[1] + ((dn[1] === 1'b1) ? 1 : 0);
      done_cnt[2] <= done_cnt[2] + ((dn[2] === 1'b1) ? 1 : 0);
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int par_of(int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
   endfunction

   function automatic int stops_of(int k);
      return (k == 0) ? 1 : 2;
   endfunction

   // Line levels of a frame, bit period 0 = start bit.
   function automatic logic [11:0] build_frame(logic [7:0] d, int par, int stops);
      logic [11:0] f;
      int n;
      f      = '0;
      f[8:1] = d;
      n      = 9;
      if (par == 1) begin
         f[9] = ~(^d);
         n    = 10;
      end else if (par == 2) begin
         f[9] = ^d;
         n    = 10;
      end
      for (int s = 0; s < stops; s++) f[n + s] = 1'b1;
      return f;
   endfunction

   task automatic push_exp(int k, logic [11:0] f);
      case (k)
         0: exp_q0.push_back(f);
         1: exp_q1.push_back(f);
         default: exp_q2.push_back(f);
      endcase
      frames_exp[k]++;
   endtask

   task automatic pop_exp(int k, output logic [11:0] f, output logic ok);
      f  = '0;
      ok = 1'b0;
      case (k)
         0: if (exp_q0.size() > 0) begin f = exp_q0.pop_front(); ok = 1'b1; end
         1: if (exp_q1.size() > 0) begin f = exp_q1.pop_front(); ok = 1'b1; end
         default: if (exp_q2.size() > 0) begin f = exp_q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // ---------------- line monitors ----------------
   task automatic monitor(int k);
      int          f;
      int          bad;
      logic [11:0] got;
      logic [11:0] exp;
      logic        ok;
      logic        gap;
      logic        aborted;
      f   = (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stops_of(k)) * C;
      gap = 1'b0;
      forever begin
         @(negedge clk);
         if (gap) begin
            check($sformatf("gap_ready%0d", k), rdy[k], 1);
            check($sformatf("gap_line%0d", k), txl[k], 1);
            gap = 1'b0;
         end
         if (!(rstn === 1'b1 && rdy[k] === 1'b1 && start_d[k] === 1'b1)) continue;
         // the next rising edge accepts a byte
         acc_prev[k] = acc_cyc[k];
         acc_cyc[k]  = cyc;
         got     = '0;
         bad     = -1;
         aborted = 1'b0;
         for (int i = 1; i <= f; i++) begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
               aborted = 1'b1;
               break;
            end
            if (bad < 0 && (rdy[k] !== 1'b0 || dn[k] !== (i == f))) bad = i;
            if (((i - 1) % C) == (C / 2)) got[(i - 1) / C] = txl[k];
         end
         if (aborted) continue;
         check($sformatf("frame_timing%0d", k), bad, -1);
         pop_exp(k, exp, ok);
         check($sformatf("exp_avail%0d", k), ok, 1);
         check($sformatf("frame_bits%0d", k), got, exp);
         gap = 1'b1;
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);

   // ---------------- driver tasks ----------------
   task automatic send(int k, logic [7:0] d, bit push);
      @(posedge clk);
      #1;
      start_d[k] = 1'b1;
      data_d[k]  = d;
      if (push) push_exp(k, build_frame(d, par_of(k), stops_of(k)));
      @(posedge clk);
      #1;
      start_d[k] = 1'b0;
      data_d[k]  = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_idle(int k);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[k] !== 1'b1 && n < 1000);
      check($sformatf("idle_reached%0d", k), rdy[k], 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rstn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_d[k] = 1'b0;
         data_d[k]  = 8'h00;
      end

      // reset held for 3 cycles, outputs idle throughout
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tx%0d", k), txl[k], 1);
            check($sformatf("rst_ready%0d", k), rdy[k], 1);
            check($sformatf("rst_done%0d", k), dn[k], 0);
         end
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_tx0", txl[0], 1);
         check("post_rst_ready0", rdy[0], 1);
         check("post_rst_done0", dn[0], 0);
      end

      // single byte
      send(0, 8'hA5, 1'b1);
      check("ready_drop", rdy[0], 0);
      wait_idle(0);

      // busy-time start and data changes are ignored
      send(0, 8'h00, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      start_d[0] = 1'b1;
      data_d[0]  = 8'hFF;
      @(posedge clk);
      #1;
      start_d[0] = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1 data_d[0] = 8'($urandom_range(0, 255));
      end
      wait_idle(0);

      // back-to-back with start held high
      @(posedge clk);
      #1;
      start_d[0] = 1'b1;
      data_d[0]  = 8'h55;
      push_exp(0, build_frame(8'h55, 0, 1));
      @(posedge clk);
      #1;
      data_d[0] = 8'h0F;
      push_exp(0, build_frame(8'h0F, 0, 1));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[0] !== 1'b1 && n < 200);
      @(posedge clk);
      #1 start_d[0] = 1'b0;
      wait_idle(0);
      check("b2b_spacing", acc_cyc[0] - acc_prev[0], 41);

      // parity and two stop bits
      send(1, 8'h07, 1'b1);
      send(2, 8'h07, 1'b1);
      wait_idle(1);
      wait_idle(2);
      for (int r = 0; r < 3; r++) begin
         send(0, 8'($urandom_range(0, 255)), 1'b1);
         send(1, 8'($urandom_range(0, 255)), 1'b1);
         send(2, 8'($urandom_range(0, 255)), 1'b1);
         wait_idle(0);
         wait_idle(1);
         wait_idle(2);
      end

      // reset during data bit 3 abandons the frame
      send(0, 8'hC3, 1'b0);
      repeat (17) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_tx", txl[0], 1);
      check("midrst_ready", rdy[0], 1);
      check("midrst_done", dn[0], 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      send(0, 8'h3C, 1'b1);
      wait_idle(0);

      repeat (6) @(negedge clk);
      check("q0_empty", exp_q0.size(), 0);
      check("q1_empty", exp_q1.size(), 0);
      check("q2_empty", exp_q2.size(), 0);
      for (int k = 0; k < 3; k++)
         check($sformatf("done_count%0d", k), done_cnt[k], frames_exp[k]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
